// File: rtl/scan_sequencer.sv
// rtl/scan_sequencer.sv - channel-select sequencer for the switch-mux / LED-decoder scan path
// Steps sel on a dwell period, samples sdata into a snapshot, supports auto/hold/step modes.
module scan_sequencer #(
    parameter int DWELL  = 33554432,
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       step_btn,
    input  logic       sdata,
    output logic [2:0] sel,
    output logic [7:0] snapshot,
    output logic       frame_done,
    output logic       scan_active
);

    localparam int PH_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [2:0]        sel_q, sel_d;
    logic [7:0]        snap_q, snap_d;
    logic [7:0]        mask_q, mask_d;
    logic              fd_q, fd_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic              step_evt;
    logic [7:0]        mask_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SCAN;
            ph_q    <= '0;
            sel_q   <= 3'd0;
            snap_q  <= 8'h00;
            mask_q  <= 8'h00;
            fd_q    <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            mask_q  <= mask_d;
            fd_q    <= fd_d;
            sync1_q <= step_btn;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // sync3_q only serves as the edge-detect history for the synchronized button
    assign step_evt = sync2_q & ~sync3_q;
    assign mask_upd = mask_q | (8'd1 << sel_q);

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        sel_d   = sel_q;
        snap_d  = snap_q;
        mask_d  = mask_q;
        fd_d    = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (ph_q == PH_W'(SETTLE)) begin
                    snap_d[sel_q] = sdata;
                    if (mask_upd == 8'hFF) begin
                        fd_d   = 1'b1;
                        mask_d = 8'h00;
                    end else begin
                        mask_d = mask_upd;
                    end
                end
                if (ph_q == PH_W'(DWELL - 1)) begin
                    case (mode)
                        2'b00: begin
                            sel_d = sel_q + 3'd1;
                            ph_d  = '0;
                        end
                        // ph stays parked at the end of the dwell while waiting
                        2'b10:   state_d = ST_WAIT;
                        default: ph_d = '0;
                    endcase
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            ST_WAIT: begin
                if (step_evt) begin
                    sel_d   = sel_q + 3'd1;
                    ph_d    = '0;
                    state_d = ST_SCAN;
                end else if (mode != 2'b10) begin
                    ph_d    = '0;
                    state_d = ST_SCAN;
                end
            end
        endcase
    end

    assign sel         = sel_q;
    assign snapshot    = snap_q;
    assign frame_done  = fd_q;
    assign scan_active = (state_q == ST_SCAN);

endmodule

// File: tb/tb_scan_sequencer.sv
// tb/tb_scan_sequencer.sv - self-checking bench for scan_sequencer against a behavioural model
module tb_scan_sequencer;

    localparam int DWELL  = 4;
    localparam int SETTLE = 1;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       step_btn;
    logic       sdata;
    logic [2:0] sel;
    logic [7:0] snapshot;
    logic       frame_done;
    logic       scan_active;
    logic [7:0] sw;

    scan_sequencer #(.DWELL(DWELL), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .step_btn    (step_btn),
        .sdata       (sdata),
        .sel         (sel),
        .snapshot    (snapshot),
        .frame_done  (frame_done),
        .scan_active (scan_active)
    );

    assign sdata = sw[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // reference model: channel, time into the current dwell, channels seen this sweep
    int       m_chan;
    int       m_t;
    bit       m_scanning;
    bit [7:0] m_snap;
    bit       m_seen [8];
    bit       m_fd;
    bit       btn_hist [3];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        m_chan = 0; m_t = 0; m_scanning = 1; m_snap = 8'h00; m_fd = 0;
        for (int i = 0; i < 8; i++) m_seen[i] = 0;
        for (int i = 0; i < 3; i++) btn_hist[i] = 0;
    endtask

    task automatic model_step();
        bit evt;
        bit all_seen;
        evt  = btn_hist[1] && !btn_hist[2];
        m_fd = 0;
        if (m_scanning) begin
            if (m_t == SETTLE) begin
                m_snap[m_chan] = sw[m_chan];
                m_seen[m_chan] = 1;
                all_seen = 1;
                for (int i = 0; i < 8; i++) all_seen = all_seen & m_seen[i];
                if (all_seen) begin
                    m_fd = 1;
                    for (int i = 0; i < 8; i++) m_seen[i] = 0;
                end
            end
            if (m_t == DWELL - 1) begin
                if (mode == 2'b00) begin
                    m_chan = (m_chan + 1) % 8;
                    m_t = 0;
                end else if (mode == 2'b10) begin
                    m_scanning = 0;
                end else begin
                    m_t = 0;
                end
            end else begin
                m_t = m_t + 1;
            end
        end else if (evt) begin
            m_chan = (m_chan + 1) % 8; m_t = 0; m_scanning = 1;
        end else if (mode != 2'b10) begin
            m_t = 0; m_scanning = 1;
        end
        btn_hist[2] = btn_hist[1];
        btn_hist[1] = btn_hist[0];
        btn_hist[0] = step_btn;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sel"},  {5'b0, sel},         8'(m_chan));
        chk({tag, ".snap"}, snapshot,            m_snap);
        chk({tag, ".fd"},   {7'b0, frame_done},  {7'b0, m_fd});
        chk({tag, ".act"},  {7'b0, scan_active}, {7'b0, m_scanning});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all("cyc");
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.sel",  {5'b0, sel},         8'h00);
        chk("rst.snap", snapshot,            8'h00);
        chk("rst.fd",   {7'b0, frame_done},  8'h00);
        chk("rst.act",  {7'b0, scan_active}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_sel(input logic [2:0] target);
        for (int i = 0; i < 80 && sel != target; i++) tick();
        chk("wait_sel", {5'b0, sel}, {5'b0, target});
    endtask

    int fd_cyc [2];
    logic [7:0] fd_snap [2];
    int fd_n;
    int hold_fd;
    logic [2:0] s0;

    initial begin
        rst_n = 1'b0; mode = 2'b00; step_btn = 1'b0; sw = 8'hA5;
        @(negedge clk);
        do_reset();

        // auto sweeps: first frame at cycle 30 with A5, then 3C one sweep later
        fd_n = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (frame_done === 1'b1 && fd_n < 2) begin
                fd_cyc[fd_n] = cyc; fd_snap[fd_n] = snapshot; fd_n++;
            end
            if (cyc == 30) sw = 8'h3C;
        end
        chk("fd_count", 8'(fd_n), 8'd2);
        chk("fd1_cycle", 8'(fd_cyc[0]), 8'd30);
        chk("fd1_snap", fd_snap[0], 8'hA5);
        chk("fd2_cycle", 8'(fd_cyc[1]), 8'd62);
        chk("fd2_snap", fd_snap[1], 8'h3C);

        // hold on channel 3 while its switch toggles
        wait_sel(3'd3);
        mode = 2'b01;
        hold_fd = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 7 == 0) sw[3] = ~sw[3];
            tick();
            if (frame_done === 1'b1) hold_fd++;
        end
        chk("hold_sel", {5'b0, sel}, 8'd3);
        chk("hold_fd", 8'(hold_fd), 8'd0);

        // step mode: button held 20 cycles gives exactly one advance, 3 edges after rise
        mode = 2'b10;
        ticks(8);
        chk("step_idle_act", {7'b0, scan_active}, 8'd0);
        s0 = sel;
        step_btn = 1'b1;
        tick(); chk("step_e1", {5'b0, sel}, {5'b0, s0});
        tick(); chk("step_e2", {5'b0, sel}, {5'b0, s0});
        tick(); chk("step_e3", {5'b0, sel}, {5'b0, 3'(s0 + 3'd1)});
        ticks(17);
        chk("step_held", {5'b0, sel}, {5'b0, 3'(s0 + 3'd1)});
        step_btn = 1'b0;
        ticks(6);

        // press while scanning (hold) is discarded and not remembered for WAIT_STEP
        s0 = sel;
        mode = 2'b01;
        ticks(2);
        step_btn = 1'b1; ticks(3);
        step_btn = 1'b0; ticks(6);
        mode = 2'b10;
        ticks(8);
        chk("scan_evt_sel", {5'b0, sel}, {5'b0, s0});
        chk("scan_evt_act", {7'b0, scan_active}, 8'd0);

        // reset mid-dwell at channel 5, then auto restarts from channel 0
        mode = 2'b00;
        wait_sel(3'd5);
        ticks(2);
        do_reset();
        ticks(3);
        chk("restart_ch0", {5'b0, sel}, 8'd0);
        tick();
        chk("restart_ch1", {5'b0, sel}, 8'd1);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
